// File: rtl/idma_rd_credit_ctrl_pkg.sv
// Shared iDMA read-path definitions: sequencer state encoding and the burst
// sizing rule used to split a descriptor into bus read bursts.
package idma_rd_credit_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_ABORT = 2'd3
    } rd_state_e;

    // Beats in the next burst: smallest of what is left, the bus maximum and
    // the distance to the next address boundary.
    function automatic int unsigned burst_calc(
        input int unsigned remaining,
        input int unsigned max_burst,
        input int unsigned boundary,
        input int unsigned addr_off
    );
        int unsigned b;
        int unsigned to_bnd;
        to_bnd = boundary - addr_off;
        b      = remaining;
        if (max_burst < b) b = max_burst;
        if (to_bnd < b)    b = to_bnd;
        return b;
    endfunction

endpackage

// File: rtl/idma_credit_cnt.sv
// Outstanding-beat counter and FIFO credit for the iDMA read path.
//   issue_i/issue_len_i   : burst accepted by the bus, adds its beats
//   rsp_valid_i           : one response beat returned
//   fifo_word_cnt_i       : current FIFO occupancy
//   outstanding_o         : beats requested but not yet returned (registered)
//   free_c                : FIFO words not yet claimed by count or outstanding
//   push_c                : response beat forwarded to the FIFO
//   err_o                 : sticky, a beat arrived with nothing outstanding
module idma_credit_cnt
    import idma_rd_credit_ctrl_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 64,
    parameter int unsigned FIFO_CNT_W = 7,
    parameter int unsigned BURST_W    = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  issue_i,
    input  logic [BURST_W-1:0]    issue_len_i,
    input  logic                  rsp_valid_i,
    input  logic [FIFO_CNT_W-1:0] fifo_word_cnt_i,
    output logic [FIFO_CNT_W-1:0] outstanding_o,
    output logic [FIFO_CNT_W:0]   free_c,
    output logic                  push_c,
    output logic                  err_o
);

    localparam int unsigned FREE_W = FIFO_CNT_W + 1;

    logic [FIFO_CNT_W-1:0] outstanding_q, outstanding_d;
    logic                  err_q, err_d;
    logic                  rsp_legal;

    // A beat only counts when something is owed; otherwise it is dropped and flagged.
    always_comb begin
        rsp_legal     = rsp_valid_i && (outstanding_q != '0);
        outstanding_d = outstanding_q;
        if (issue_i) begin
            outstanding_d = outstanding_d + FIFO_CNT_W'(issue_len_i);
        end
        if (rsp_legal) begin
            outstanding_d = outstanding_d - FIFO_CNT_W'(1);
        end
        err_d  = err_q | (rsp_valid_i && !rsp_legal);
        push_c = rsp_legal;
        free_c = FREE_W'(FIFO_DEPTH) - FREE_W'(fifo_word_cnt_i) - FREE_W'(outstanding_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding_q <= '0;
            err_q         <= 1'b0;
        end else begin
            outstanding_q <= outstanding_d;
            err_q         <= err_d;
        end
    end

    assign outstanding_o = outstanding_q;
    assign err_o         = err_q;

endmodule

// File: rtl/idma_rd_credit_ctrl.sv
// iDMA read-side sequencer: splits one descriptor at a time into bounded
// read bursts, raising a burst only when the FIFO can absorb every beat it
// will return, and sequences a FIFO clear when a descriptor is aborted.
//   desc_*        : descriptor handshake (start beat address, beat count)
//   abort         : single-cycle cancel of the running descriptor
//   rd_req_*      : burst request to the bus (held until accepted)
//   rd_rsp_valid  : response beat; fifo_push forwards it combinationally
//   fifo_word_cnt : FIFO occupancy; fifo_init clears FIFO pointers
//   busy/done/aborted/err : status (done/aborted are one-cycle pulses)
module idma_rd_credit_ctrl
    import idma_rd_credit_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned LEN_W      = 16,
    parameter int unsigned MAX_BURST  = 16,
    parameter int unsigned BOUNDARY   = 16,
    parameter int unsigned FIFO_DEPTH = 64,
    parameter int unsigned FIFO_CNT_W = 7,
    parameter int unsigned BURST_W    = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  desc_valid,
    output logic                  desc_ready,
    input  logic [ADDR_W-1:0]     desc_addr,
    input  logic [LEN_W-1:0]      desc_len,
    input  logic                  abort,
    output logic                  rd_req_valid,
    input  logic                  rd_req_ready,
    output logic [ADDR_W-1:0]     rd_req_addr,
    output logic [BURST_W-1:0]    rd_req_len,
    input  logic                  rd_rsp_valid,
    output logic                  fifo_push,
    input  logic [FIFO_CNT_W-1:0] fifo_word_cnt,
    output logic                  fifo_init,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted,
    output logic                  err
);

    localparam int unsigned FREE_W = FIFO_CNT_W + 1;

    rd_state_e             state_q, state_d;
    logic [ADDR_W-1:0]     cur_addr_q, cur_addr_d;
    logic [LEN_W-1:0]      remaining_q, remaining_d;
    logic                  abort_pend_q, abort_pend_d;
    logic                  req_valid_q, req_valid_d;
    logic [ADDR_W-1:0]     req_addr_q, req_addr_d;
    logic [BURST_W-1:0]    req_len_q, req_len_d;
    logic                  done_q, done_d;
    logic                  aborted_q, aborted_d;
    logic                  fifo_init_q, fifo_init_d;
    logic                  busy_q, desc_ready_q;

    logic [FIFO_CNT_W-1:0] outstanding;
    logic [FIFO_CNT_W:0]   free;
    logic [BURST_W-1:0]    burst;
    logic                  req_hs;
    logic                  abort_any;
    int unsigned           rem_clip;
    int unsigned           addr_off;

    idma_credit_cnt #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .FIFO_CNT_W (FIFO_CNT_W),
        .BURST_W    (BURST_W)
    ) u_credit (
        .clk             (clk),
        .rst_n           (rst_n),
        .issue_i         (req_hs),
        .issue_len_i     (req_len_q),
        .rsp_valid_i     (rd_rsp_valid),
        .fifo_word_cnt_i (fifo_word_cnt),
        .outstanding_o   (outstanding),
        .free_c          (free),
        .push_c          (fifo_push),
        .err_o           (err)
    );

    // Next burst size; remaining is clipped first so it fits the 32-bit helper.
    always_comb begin
        rem_clip = (remaining_q > LEN_W'(MAX_BURST)) ? MAX_BURST : 32'(remaining_q);
        addr_off = 32'(cur_addr_q & ADDR_W'(BOUNDARY - 1));
        burst    = BURST_W'(burst_calc(rem_clip, MAX_BURST, BOUNDARY, addr_off));
    end

    assign req_hs = req_valid_q && rd_req_ready;

    // Sequencer next state. An abort never cuts a raised request short: the
    // held request completes its handshake before the FSM moves to ABORT.
    always_comb begin
        state_d      = state_q;
        cur_addr_d   = cur_addr_q;
        remaining_d  = remaining_q;
        abort_pend_d = abort_pend_q;
        req_valid_d  = req_valid_q;
        req_addr_d   = req_addr_q;
        req_len_d    = req_len_q;
        done_d       = 1'b0;
        aborted_d    = 1'b0;
        fifo_init_d  = 1'b0;
        abort_any    = abort_pend_q ||
                       (abort && ((state_q == ST_ISSUE) || (state_q == ST_DRAIN)));

        unique case (state_q)
            ST_IDLE: begin
                abort_pend_d = 1'b0;
                if (desc_valid) begin
                    if (desc_len != '0) begin
                        cur_addr_d  = desc_addr;
                        remaining_d = desc_len;
                        state_d     = ST_ISSUE;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                abort_pend_d = abort_any;
                if (req_hs) begin
                    req_valid_d = 1'b0;
                    cur_addr_d  = cur_addr_q + ADDR_W'(req_len_q);
                    remaining_d = remaining_q - LEN_W'(req_len_q);
                    if (abort_any) begin
                        state_d = ST_ABORT;
                    end else if (remaining_d == '0) begin
                        state_d = ST_DRAIN;
                    end
                end else if (!req_valid_q) begin
                    if (abort_any) begin
                        state_d = ST_ABORT;
                    end else if (FREE_W'(burst) <= free) begin
                        req_valid_d = 1'b1;
                        req_addr_d  = cur_addr_q;
                        req_len_d   = burst;
                    end
                end
            end
            ST_DRAIN: begin
                abort_pend_d = abort_any;
                if (abort_any) begin
                    state_d = ST_ABORT;
                end else if (outstanding == '0) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            ST_ABORT: begin
                if (outstanding == '0) begin
                    state_d      = ST_IDLE;
                    aborted_d    = 1'b1;
                    fifo_init_d  = 1'b1;
                    abort_pend_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cur_addr_q   <= '0;
            remaining_q  <= '0;
            abort_pend_q <= 1'b0;
            req_valid_q  <= 1'b0;
            req_addr_q   <= '0;
            req_len_q    <= '0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            fifo_init_q  <= 1'b0;
            busy_q       <= 1'b0;
            desc_ready_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            cur_addr_q   <= cur_addr_d;
            remaining_q  <= remaining_d;
            abort_pend_q <= abort_pend_d;
            req_valid_q  <= req_valid_d;
            req_addr_q   <= req_addr_d;
            req_len_q    <= req_len_d;
            done_q       <= done_d;
            aborted_q    <= aborted_d;
            fifo_init_q  <= fifo_init_d;
            busy_q       <= (state_d != ST_IDLE);
            desc_ready_q <= (state_d == ST_IDLE);
        end
    end

    assign desc_ready   = desc_ready_q;
    assign busy         = busy_q;
    assign rd_req_valid = req_valid_q;
    assign rd_req_addr  = req_addr_q;
    assign rd_req_len   = req_len_q;
    assign done         = done_q;
    assign aborted      = aborted_q;
    assign fifo_init    = fifo_init_q;

endmodule

// File: tb/tb_idma_rd_credit_ctrl.sv
// Bench for idma_rd_credit_ctrl: a beat-level bus responder and FIFO model
// drive the sequencer; expected bursts come from an arithmetic split of the
// descriptor, credit safety from the FIFO occupancy model.
module tb_idma_rd_credit_ctrl;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned LEN_W      = 16;
    localparam int unsigned MAX_BURST  = 16;
    localparam int unsigned BOUNDARY   = 16;
    localparam int unsigned FIFO_DEPTH = 64;
    localparam int unsigned FIFO_CNT_W = 7;
    localparam int unsigned BURST_W    = 5;
    localparam int          MAX_CYC    = 2000;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  desc_valid;
    logic                  desc_ready;
    logic [ADDR_W-1:0]     desc_addr;
    logic [LEN_W-1:0]      desc_len;
    logic                  abort;
    logic                  rd_req_valid;
    logic                  rd_req_ready;
    logic [ADDR_W-1:0]     rd_req_addr;
    logic [BURST_W-1:0]    rd_req_len;
    logic                  rd_rsp_valid;
    logic                  fifo_push;
    logic [FIFO_CNT_W-1:0] fifo_word_cnt;
    logic                  fifo_init;
    logic                  busy;
    logic                  done;
    logic                  aborted;
    logic                  err;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          fifo_cnt = 0;
    int          out_m    = 0;
    logic        err_m    = 1'b0;
    logic [31:0] exp_addr[$];
    int          exp_len[$];

    always #5 clk = ~clk;

    idma_rd_credit_ctrl #(
        .ADDR_W(ADDR_W), .LEN_W(LEN_W), .MAX_BURST(MAX_BURST), .BOUNDARY(BOUNDARY),
        .FIFO_DEPTH(FIFO_DEPTH), .FIFO_CNT_W(FIFO_CNT_W), .BURST_W(BURST_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .desc_valid(desc_valid), .desc_ready(desc_ready),
        .desc_addr(desc_addr), .desc_len(desc_len), .abort(abort),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
        .rd_req_addr(rd_req_addr), .rd_req_len(rd_req_len),
        .rd_rsp_valid(rd_rsp_valid), .fifo_push(fifo_push),
        .fifo_word_cnt(fifo_word_cnt), .fifo_init(fifo_init),
        .busy(busy), .done(done), .aborted(aborted), .err(err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference split of a descriptor into bursts.
    function automatic void plan(input logic [31:0] a, input int len);
        int          rem = len;
        logic [31:0] cur = a;
        int          b;
        int          to_bnd;
        exp_addr.delete();
        exp_len.delete();
        while (rem > 0) begin
            to_bnd = int'(BOUNDARY) - int'(cur % BOUNDARY);
            b = rem;
            if (b > int'(MAX_BURST)) b = int'(MAX_BURST);
            if (b > to_bnd) b = to_bnd;
            exp_addr.push_back(cur);
            exp_len.push_back(b);
            cur = cur + 32'(b);
            rem -= b;
        end
    endfunction

    task automatic idle_inputs();
        desc_valid   = 1'b0;
        rd_req_ready = 1'b0;
        rd_rsp_valid = 1'b0;
        abort        = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_desc_ready"}, 64'(desc_ready), 64'(1));
        chk({tag, "_req_valid"},  64'(rd_req_valid), 64'(0));
        chk({tag, "_req_addr"},   64'(rd_req_addr), 64'(0));
        chk({tag, "_req_len"},    64'(rd_req_len), 64'(0));
        chk({tag, "_busy"},       64'(busy), 64'(0));
        chk({tag, "_done"},       64'(done), 64'(0));
        chk({tag, "_aborted"},    64'(aborted), 64'(0));
        chk({tag, "_fifo_init"},  64'(fifo_init), 64'(0));
        chk({tag, "_err"},        64'(err), 64'(0));
    endtask

    // One descriptor from handshake to done/aborted. abort_idx selects the burst
    // (0-based) whose request gets aborted while held; -1 for none.
    task automatic run(input logic [31:0] a, input int len, input int rdy_pct, input int rsp_pct,
                       input int pop_pct, input int pop_start, input int abort_idx,
                       input bit stall_chk);
        int          end_k = -1;
        int          hs_cnt = 0;
        int          hold = 0;
        int          avail;
        bit          abort_mode = 1'b0;
        bit          finished = 1'b0;
        bit          first_ok, v, is_new, rdy, rsp, pop;
        bit          prev_v = 1'b0;
        bit          prev_r = 1'b0;
        logic [31:0] prev_a = '0;
        logic [BURST_W-1:0] prev_l = '0;

        plan(a, len);
        @(negedge clk);
        chk("desc_ready_start", 64'(desc_ready), 64'(1));
        idle_inputs();
        desc_valid    = 1'b1;
        desc_addr     = a;
        desc_len      = LEN_W'(len);
        fifo_word_cnt = FIFO_CNT_W'(fifo_cnt);
        first_ok = (exp_len.size() > 0) && (exp_len[0] <= int'(FIFO_DEPTH) - fifo_cnt - out_m);
        if (len == 0) end_k = 1;

        for (int k = 1; k <= MAX_CYC; k++) begin
            @(negedge clk);
            desc_valid = 1'b0;
            v = rd_req_valid;
            chk("done",      64'(done),      64'((k == end_k) && !abort_mode));
            chk("aborted",   64'(aborted),   64'((k == end_k) && abort_mode));
            chk("fifo_init", 64'(fifo_init), 64'((k == end_k) && abort_mode));
            chk("busy",      64'(busy),      64'(k != end_k));
            chk("err",       64'(err),       64'(err_m));
            if (k == end_k) begin
                chk("desc_ready_end", 64'(desc_ready), 64'(1));
                chk("req_valid_end",  64'(v), 64'(0));
                finished = 1'b1;
                break;
            end

            is_new = 1'b0;
            if (prev_v && !prev_r) begin
                chk("req_hold_valid", 64'(v), 64'(1));
                chk("req_hold_addr",  64'(rd_req_addr), 64'(prev_a));
                chk("req_hold_len",   64'(rd_req_len), 64'(prev_l));
            end else if (prev_v && prev_r) begin
                chk("req_drop", 64'(v), 64'(0));
            end else if (v) begin
                is_new = 1'b1;
                if (exp_len.size() == 0) begin
                    chk("req_extra", 64'(v), 64'(0));
                end else begin
                    chk("req_addr", 64'(rd_req_addr), 64'(exp_addr[0]));
                    chk("req_len",  64'(rd_req_len), 64'(exp_len[0]));
                    avail = int'(FIFO_DEPTH) - fifo_cnt - out_m;
                    chk("req_credit", 64'(int'(rd_req_len) <= avail), 64'(1));
                end
                if (hs_cnt == 0 && first_ok) chk("first_req_latency", 64'(k), 64'(2));
            end

            if (stall_chk && k == pop_start) begin
                chk("stall_bursts", 64'(hs_cnt), 64'(4));
                chk("stall_valid",  64'(v), 64'(0));
            end

            abort = 1'b0;
            if (is_new && hs_cnt == abort_idx && !abort_mode) begin
                abort      = 1'b1;
                abort_mode = 1'b1;
                hold       = 3;
            end
            if (hold > 0) begin
                rdy = 1'b0;
                hold--;
            end else begin
                rdy = int'($urandom_range(99)) < rdy_pct;
            end
            rsp = (out_m > 0) && (int'($urandom_range(99)) < rsp_pct);
            pop = (k >= pop_start) && (fifo_cnt > 0) && (int'($urandom_range(99)) < pop_pct);

            rd_req_ready  = rdy;
            rd_rsp_valid  = rsp;
            fifo_word_cnt = FIFO_CNT_W'(fifo_cnt);
            #1;
            chk("fifo_push", 64'(fifo_push), 64'(rsp));

            if (rsp) begin
                out_m--;
                fifo_cnt++;
            end
            if (pop) fifo_cnt--;
            if (v && rdy) begin
                out_m += int'(rd_req_len);
                hs_cnt++;
                if (exp_len.size() > 0) begin
                    void'(exp_addr.pop_front());
                    void'(exp_len.pop_front());
                end
                if (abort_mode) begin
                    exp_addr.delete();
                    exp_len.delete();
                end
            end
            if (rsp) chk("fifo_no_overflow", 64'(fifo_cnt <= int'(FIFO_DEPTH)), 64'(1));
            if (rsp && out_m == 0 && exp_len.size() == 0) end_k = k + 2;

            prev_v = v;
            prev_r = rdy;
            prev_a = rd_req_addr;
            prev_l = rd_req_len;
        end
        chk("descriptor_complete", 64'(finished), 64'(1));
        idle_inputs();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra;
        rst_n         = 1'b0;
        idle_inputs();
        desc_addr     = '0;
        desc_len      = '0;
        fifo_word_cnt = '0;
        repeat (3) @(negedge clk);
        chk_reset_state("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Plain split, boundary crossing, credit stall then release.
        run(32'h0000_0000, 40, 100, 100, 100, 0, -1, 1'b0);
        run(32'h0000_000C, 10, 100, 100, 100, 0, -1, 1'b0);
        run(32'h0000_0000, 100, 100, 100, 100, 80, -1, 1'b1);
        // Abort on the second request while it is held.
        run(32'h0000_0000, 64, 100, 100, 100, 0, 1, 1'b0);
        // Zero length.
        run(32'h0000_1234, 0, 100, 100, 100, 0, -1, 1'b0);

        // Randomized descriptors, addresses near boundaries and the wrap point.
        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            if (i % 4 == 0) ra = 32'hFFFF_FFC0 | 32'($urandom_range(63));
            run(ra, int'($urandom_range(90)), int'($urandom_range(100, 30)),
                int'($urandom_range(100, 20)), int'($urandom_range(100, 20)), 0,
                ($urandom_range(3) == 0) ? int'($urandom_range(3)) : -1, 1'b0);
        end

        // Spurious response in IDLE.
        @(negedge clk);
        rd_rsp_valid = 1'b1;
        #1;
        chk("spurious_push", 64'(fifo_push), 64'(0));
        @(negedge clk);
        rd_rsp_valid = 1'b0;
        err_m = 1'b1;
        chk("spurious_err", 64'(err), 64'(1));
        repeat (3) @(negedge clk);
        chk("spurious_err_sticky", 64'(err), 64'(1));
        run(32'h0000_0020, 20, 100, 100, 100, 0, -1, 1'b0);

        // Reset in the middle of a transfer.
        @(negedge clk);
        desc_valid = 1'b1;
        desc_addr  = 32'h0;
        desc_len   = LEN_W'(64);
        @(negedge clk);
        desc_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("midreset_req_up", 64'(rd_req_valid), 64'(1));
        rst_n = 1'b0;
        #1;
        chk_reset_state("midreset");
        @(negedge clk);
        rst_n    = 1'b1;
        out_m    = 0;
        fifo_cnt = 0;
        err_m    = 1'b0;
        run(32'h0000_0008, 30, 80, 80, 80, 0, -1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/idma_rd_credit_ctrl.md
# idma_rd_credit_ctrl

Read-side sequencer for the iDMA 128-bit read path. It accepts one transfer descriptor at a time and splits it into bus read bursts that respect the maximum burst length and the address boundary. It issues a burst only when the downstream `fifo_sync_sram` is guaranteed to have room for every returned beat, because response beats are pushed into that FIFO unconditionally. It also sequences FIFO re-initialisation on abort.

## Interface
Parameters:
- `ADDR_W`, 32: beat-address width; addresses are in beats, not bytes.
- `LEN_W`, 16: descriptor length width, in beats.
- `MAX_BURST`, 16: maximum beats per burst; must be ≤ `FIFO_DEPTH`.
- `BOUNDARY`, 16: bursts never cross a multiple of this many beats; must be a power of 2.
- `FIFO_DEPTH`, 64: capacity of the attached FIFO SRAM.
- `FIFO_CNT_W`, 7: width of `fifo_word_cnt`, equal to clog2(`FIFO_DEPTH`)+1.
- `BURST_W`, 5: width of `rd_req_len`, equal to clog2(`MAX_BURST`)+1.

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset; asynchronous, active-low
- `desc_valid`  in  1  descriptor offered
- `desc_ready`  out  1  descriptor accepted when both `desc_valid` and `desc_ready` are high
- `desc_addr`  in  `ADDR_W`  start beat address
- `desc_len`  in  `LEN_W`  beat count; 0 is legal
- `abort`  in  1  single-cycle request to cancel the current descriptor
- `rd_req_valid`  out  1  burst request valid
- `rd_req_ready`  in  1  bus accepts the burst
- `rd_req_addr`  out  `ADDR_W`  burst start beat address
- `rd_req_len`  out  `BURST_W`  burst beats, range 1..`MAX_BURST`
- `rd_rsp_valid`  in  1  one response beat returned
- `fifo_push`  out  1  push to FIFO, combinational from `rd_rsp_valid`
- `fifo_word_cnt`  in  `FIFO_CNT_W`  FIFO occupancy
- `fifo_init`  out  1  one-cycle FIFO pointer clear
- `busy`  out  1  state is not IDLE
- `done`  out  1  one-cycle pulse when a descriptor completes normally
- `aborted`  out  1  one-cycle pulse when an abort completes
- `err`  out  1  sticky flag: a response beat arrived with nothing outstanding

## Operation
- FSM states: IDLE, ISSUE, DRAIN, ABORT. `desc_ready` = (state==IDLE).
- **IDLE**:
  - Handshake with `desc_len`≠0: load `cur_addr`, `remaining`, then go to ISSUE.
  - Handshake with `desc_len`=0: pulse `done` next cycle and stay in IDLE.
- **Burst size**: `burst` = min(`remaining`, `MAX_BURST`, `BOUNDARY` − (`cur_addr` mod `BOUNDARY`)).
- **Credit**: `free` = `FIFO_DEPTH` − `fifo_word_cnt` − `outstanding`, computed `FIFO_CNT_W`+1 bits wide.
  - It is never negative by construction.
  - While no burst is issued, `free` is non-decreasing: a push moves a beat from `outstanding` to count, and a pop lowers count.
- **ISSUE**:
  - When `rd_req_valid`=0, `burst`≤`free`, and no abort is pending: register `rd_req_valid`=1, `rd_req_addr`=`cur_addr`, `rd_req_len`=`burst`.
  - Once asserted, valid, addr and len hold stable until `rd_req_ready`.
  - On handshake: `outstanding` += `burst`, `cur_addr` += `burst`, `remaining` −= `burst`, valid drops next cycle.
  - If `remaining` reaches 0, go to DRAIN.
- **DRAIN**: when `outstanding`==0, go to IDLE and pulse `done`.
- **Abort**:
  - `abort` sampled in ISSUE or DRAIN sets `abort_pend`.
  - A request already asserted completes its handshake first; no new request is raised.
  - Then go to ABORT. When `outstanding`==0, pulse `fifo_init` and `aborted`, clear `abort_pend`, and go to IDLE.
  - `abort` in IDLE is ignored.
- **Response accounting**:
  - `rd_rsp_valid` with `outstanding`>0 decrements `outstanding`.
  - `rd_rsp_valid` with `outstanding`==0 sets `err` and forces `fifo_push`=0.
  - A handshake and a response in the same cycle give `outstanding` += `burst` − 1.
- **Register widths**:
  - `outstanding` is `FIFO_CNT_W` bits and saturates at neither end; an illegal response never decrements it.
  - `cur_addr` wraps modulo 2^`ADDR_W`.

## Timing
- **Reset values**:
  - State IDLE, so `desc_ready`=1.
  - `rd_req_valid`=0, `rd_req_addr`=0, `rd_req_len`=0.
  - `fifo_init`=0, `busy`=0, `done`=0, `aborted`=0, `err`=0, `outstanding`=0.
- **Request timing**:
  - First `rd_req_valid` appears 2 cycles after the descriptor handshake when credit suffices (cycle 1 ISSUE, cycle 2 valid).
  - Back-to-back bursts: the next valid comes 2 cycles after the previous handshake (one bubble).
- **Completion timing**:
  - `done` is high in the first IDLE cycle, coincident with `desc_ready`=1.
  - A new descriptor may handshake in that same cycle.
- **Combinational path**: `fifo_push` is combinational, with zero latency from `rd_rsp_valid`.
- **Mid-operation reset**: `rst_n` asserted mid-transfer clears everything immediately. The FIFO is reset by the same `rst_n`, so no `fifo_init` is needed.

## Structure
- Shared iDMA package holds:
  - The FSM state enum (IDLE, ISSUE, DRAIN, ABORT).
  - A `burst_calc` function: min of remaining, max burst and distance to boundary.
- One natural sub-module, `idma_credit_cnt`, holds the `outstanding` counter plus the `free`/err logic.
- The FSM and address/remaining registers stay in the top module.

## Test plan
- **Plain split**: `desc_addr`=0x0, `desc_len`=40, FIFO popped continuously -> bursts (0x0,16), (0x10,16), (0x20,8); `done` pulses after the 40th response beat.
- **Boundary crossing**: `desc_addr`=0x0C, `desc_len`=10 -> bursts (0x0C,4), (0x10,6).
- **Credit backpressure**: `desc_len`=100, no pops, responses returned immediately -> four 16-beat bursts (64 beats), then `rd_req_valid` stays 0. Pop 16 words -> burst (0x40,16) issues.
- **Abort mid-transfer**: `abort` while `rd_req_valid`=1 and `rd_req_ready`=0 -> valid held until ready, no further requests. After the last outstanding beat: `fifo_init` and `aborted` pulse for one cycle, `done` never pulses.
- **Zero length**: `desc_len`=0 -> `done` pulses the next cycle, no request is issued, `busy` stays 0.
- **Spurious response**: `rd_rsp_valid` in IDLE -> `err`=1 (sticky until reset), `fifo_push`=0, `outstanding` stays 0.
